regfile_sb: RTL and testbench

- Integer register file with an attached write-pending scoreboard. It is the consumer of the writeback stage outputs: write data, write enable and destination register.
- Two combinational read ports serve decode. A same-cycle writeback is bypassed into the read data.
- The scoreboard tracks registers with an in-flight producer and raises `hazard` so decode can stall issue.

---
 rtl/regfile_sb.sv | 122 ++++++++++++
 tb/tb_regfile_sb.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: 31 x DATA_WIDTH integer register file (x0 hardwired to 0)
// with writeback bypass and a write-pending scoreboard for decode stalls.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   rs1_addr/rs1_data read port 1 (combinational, bypassed)
//   rs2_addr/rs2_data read port 2 (combinational, bypassed)
//   wb_en/wb_rd/wb_data  writeback write port, clears the busy bit
//   iss_*             issuing instruction: rd, writes, rs1/rs2 used
//   flush             drops every pending producer
//   hazard            combinational stall request for the issue
//   busy_mask         registered scoreboard, bit i = xi write pending
module regfile_sb #(
   parameter int DATA_WIDTH  = 32,
   parameter bit RESET_CLEAR = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4:0]            rs1_addr,
   input  logic [4:0]            rs2_addr,
   output logic [DATA_WIDTH-1:0] rs1_data,
   output logic [DATA_WIDTH-1:0] rs2_data,
   input  logic                  wb_en,
   input  logic [4:0]            wb_rd,
   input  logic [DATA_WIDTH-1:0] wb_data,
   input  logic                  iss_valid,
   input  logic [4:0]            iss_rd,
   input  logic                  iss_writes,
   input  logic                  iss_rs1_used,
   input  logic                  iss_rs2_used,
   input  logic                  flush,
   output logic                  hazard,
   output logic [31:0]           busy_mask
);

   // Entry 0 is never written and never read (reads of x0 are muxed).
   logic [DATA_WIDTH-1:0] regs [0:31];
   logic [31:0]           busy_q;

   logic wb_wr;
   logic pend_rs1;
   logic pend_rs2;
   logic pend_rd;
   logic raw;
   logic waw;
   logic iss_fire;

   logic [31:0] set_mask;
   logic [31:0] clr_mask;

   assign wb_wr = wb_en && (wb_rd != 5'd0);

   // A register being written back this cycle is no longer pending.
   function automatic logic pending(input logic [4:0] r);
      return busy_q[r] && !(wb_en && (wb_rd == r));
   endfunction

   always_comb begin
      pend_rs1 = pending(rs1_addr);
      pend_rs2 = pending(rs2_addr);
      pend_rd  = pending(iss_rd);
      raw = (iss_rs1_used && pend_rs1)
         || (iss_rs2_used && pend_rs2);
      waw = iss_writes && (iss_rd != 5'd0) && pend_rd;
   end

   assign hazard = iss_valid && !flush && (raw || waw);

   assign iss_fire = iss_valid && !hazard && !flush
                  && iss_writes && (iss_rd != 5'd0);

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (iss_fire) set_mask[iss_rd] = 1'b1;
      if (wb_wr)    clr_mask[wb_rd]  = 1'b1;
   end

   // Set wins over clear: a new producer issued while the old one
   // writes back must stay tracked.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else if (flush) begin
         busy_q <= '0;
      end else begin
         busy_q <= ((busy_q & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
      end
   end

   assign busy_mask = busy_q;

   // Writeback still lands during a flush; only reset blocks it.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (RESET_CLEAR) begin
            for (int i = 1; i < 32; i++) regs[i] <= '0;
         end
      end else if (wb_wr) begin
         regs[wb_rd] <= wb_data;
      end
   end

   always_comb begin
      if (rs1_addr == 5'd0)
         rs1_data = '0;
      else if (wb_en && (wb_rd == rs1_addr))
         rs1_data = wb_data;
      else
         rs1_data = regs[rs1_addr];
   end

   always_comb begin
      if (rs2_addr == 5'd0)
         rs2_data = '0;
      else if (wb_en && (wb_rd == rs2_addr))
         rs2_data = wb_data;
      else
         rs2_data = regs[rs2_addr];
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed bench for regfile_sb.
// Linear stimulus; every check compares against hand-computed values.
module tb_regfile_sb;

   logic        clk;
   logic        rst;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        iss_writes;
   logic        iss_rs1_used;
   logic        iss_rs2_used;
   logic        flush;
   logic        hazard;
   logic [31:0] busy_mask;

   int tests;
   int fails;

   regfile_sb #(
      .DATA_WIDTH  (32),
      .RESET_CLEAR (1'b1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data),
      .wb_en        (wb_en),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .iss_valid    (iss_valid),
      .iss_rd       (iss_rd),
      .iss_writes   (iss_writes),
      .iss_rs1_used (iss_rs1_used),
      .iss_rs2_used (iss_rs2_used),
      .flush        (flush),
      .hazard       (hazard),
      .busy_mask    (busy_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_en        = 1'b0;
      wb_rd        = '0;
      wb_data      = '0;
      iss_valid    = 1'b0;
      iss_rd       = '0;
      iss_writes   = 1'b0;
      iss_rs1_used = 1'b0;
      iss_rs2_used = 1'b0;
      flush        = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd);
      iss_valid  = 1'b1;
      iss_writes = 1'b1;
      iss_rd     = rd;
      tick();
      idle();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      idle();
      rs1_addr = '0;
      rs2_addr = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;

      // Reset state
      check("rst_busy", busy_mask, 32'h0);
      check("rst_hazard", {31'b0, hazard}, 32'h0);
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i);
         rs2_addr = 5'(31 - i);
         #1;
         check($sformatf("rst_rs1_x%0d", i), rs1_data, 32'h0);
         check($sformatf("rst_rs2_x%0d", 31 - i), rs2_data, 32'h0);
      end

      // x0 write discarded, bypass suppressed
      rs1_addr = 5'd0;
      wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEADBEEF;
      #1;
      check("x0_bypass", rs1_data, 32'h0);
      tick();
      idle();
      #1;
      check("x0_read", rs1_data, 32'h0);
      check("x0_busy", busy_mask, 32'h0);

      // Write with same-cycle bypass
      rs1_addr = 5'd5; rs2_addr = 5'd6;
      wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hA1A1A1A1;
      #1;
      check("byp_rs1", rs1_data, 32'hA1A1A1A1);
      check("byp_rs2_other", rs2_data, 32'h0);
      tick();
      idle();
      #1;
      check("wr_rs1", rs1_data, 32'hA1A1A1A1);

      // RAW stall and release
      iss_valid = 1'b1; iss_writes = 1'b1; iss_rd = 5'd7;
      #1;
      check("iss7_hazard", {31'b0, hazard}, 32'h0);
      tick();
      idle();
      #1;
      check("iss7_busy", busy_mask, 32'h80);
      rs1_addr = 5'd7; rs2_addr = 5'd7;
      iss_valid = 1'b1; iss_rs1_used = 1'b1;
      iss_writes = 1'b1; iss_rd = 5'd8;
      #1;
      check("raw1_hazard", {31'b0, hazard}, 32'h1);
      tick();
      check("stall_no_set", busy_mask, 32'h80);
      iss_rs1_used = 1'b0; iss_rs2_used = 1'b1; iss_writes = 1'b0;
      #1;
      check("raw2_hazard", {31'b0, hazard}, 32'h1);
      iss_rs2_used = 1'b0;
      #1;
      check("unused_no_haz", {31'b0, hazard}, 32'h0);
      iss_rs1_used = 1'b1;
      wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hB2B2B2B2;
      #1;
      check("raw_rel_hazard", {31'b0, hazard}, 32'h0);
      check("raw_rel_data", rs1_data, 32'hB2B2B2B2);
      tick();
      idle();
      #1;
      check("raw_rel_busy", busy_mask, 32'h0);
      check("raw_rel_read", rs1_data, 32'hB2B2B2B2);

      // WAW and set-wins
      issue(5'd9);
      check("iss9_busy", busy_mask, 32'h200);
      iss_valid = 1'b1; iss_writes = 1'b1; iss_rd = 5'd9;
      #1;
      check("waw_hazard", {31'b0, hazard}, 32'h1);
      flush = 1'b1;
      #1;
      check("flush_gate_haz", {31'b0, hazard}, 32'h0);
      flush = 1'b0;
      wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'hC3C3C3C3;
      #1;
      check("waw_rel_hazard", {31'b0, hazard}, 32'h0);
      tick();
      idle();
      rs1_addr = 5'd9;
      #1;
      check("set_wins_busy", busy_mask, 32'h200);
      check("set_wins_data", rs1_data, 32'hC3C3C3C3);
      wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h12345678;
      tick();
      idle();
      #1;
      check("x9_clear_busy", busy_mask, 32'h0);
      check("x9_clear_data", rs1_data, 32'h12345678);

      // Flush with issue and writeback in the same cycle
      issue(5'd3);
      issue(5'd4);
      issue(5'd31);
      check("fl_pre_busy", busy_mask, 32'h80000018);
      iss_valid = 1'b1; iss_writes = 1'b1; iss_rd = 5'd6;
      wb_en = 1'b1; wb_rd = 5'd10; wb_data = 32'h55AA55AA;
      flush = 1'b1;
      #1;
      check("fl_hazard", {31'b0, hazard}, 32'h0);
      tick();
      idle();
      rs1_addr = 5'd10;
      #1;
      check("fl_busy", busy_mask, 32'h0);
      check("fl_wb_data", rs1_data, 32'h55AA55AA);

      // Reset mid-operation
      issue(5'd12);
      check("x12_busy", busy_mask, 32'h1000);
      rst = 1'b1;
      iss_valid = 1'b1; iss_writes = 1'b1; iss_rd = 5'd12;
      #1;
      check("rst_haz_indep", {31'b0, hazard}, 32'h1);
      iss_rd = 5'd13;
      wb_en = 1'b1; wb_rd = 5'd12; wb_data = 32'hEEEEEEEE;
      tick();
      rst = 1'b0;
      idle();
      rs1_addr = 5'd12; rs2_addr = 5'd10;
      #1;
      check("rst2_busy", busy_mask, 32'h0);
      check("rst2_x12", rs1_data, 32'h0);
      check("rst2_x10", rs2_data, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
